// File: rtl/spi_encoder.sv
// SPI mode-0 transmitter: shifts bytes out MSB first on sck/mosi framed by cs_n.
// Back-to-back bytes keep cs_n low when the next byte is offered in the last TAIL cycle.
module spi_encoder #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       abort,
  output logic       sck,
  output logic       mosi,
  output logic       cs_n,
  output logic       busy,
  output logic       done
);

  // state | meaning
  // IDLE  | bus released, waiting for a byte
  // SETUP | cs_n low, MSB on mosi, sck low for one half period
  // HI    | sck high, receiver samples mosi
  // LO    | sck low, next bit presented on mosi
  // TAIL  | sck low after the last bit; can chain into the next byte
  typedef enum logic [2:0] {IDLE, SETUP, HI, LO, TAIL} state_t;

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  state_t          state;
  logic [PW-1:0]   phase;
  logic [7:0]      shreg;
  logic [2:0]      bit_idx;
  logic            last_phase;
  logic            accept;

  assign last_phase = (phase == LAST);
  // Abort wins over a chained accept, so the handshake is withheld in that cycle.
  assign in_ready   = (state == IDLE) || ((state == TAIL) && last_phase && !abort);
  assign accept     = in_valid && in_ready;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      phase   <= '0;
      shreg   <= '0;
      bit_idx <= '0;
      sck     <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= 1'b1;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && (state != IDLE)) begin
        state   <= IDLE;
        phase   <= '0;
        bit_idx <= '0;
        sck     <= 1'b0;
        mosi    <= 1'b0;
        cs_n    <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              shreg   <= in_data;
              bit_idx <= 3'd7;
              phase   <= '0;
              cs_n    <= 1'b0;
              sck     <= 1'b0;
              mosi    <= in_data[7];
              state   <= SETUP;
            end
          end
          SETUP: begin
            if (last_phase) begin
              phase <= '0;
              sck   <= 1'b1;
              state <= HI;
            end else begin
              phase <= phase + 1'b1;
            end
          end
          HI: begin
            if (last_phase) begin
              phase <= '0;
              sck   <= 1'b0;
              if (bit_idx != 3'd0) begin
                mosi    <= shreg[bit_idx - 3'd1];
                bit_idx <= bit_idx - 3'd1;
                state   <= LO;
              end else begin
                state <= TAIL;
              end
            end else begin
              phase <= phase + 1'b1;
            end
          end
          LO: begin
            if (last_phase) begin
              phase <= '0;
              sck   <= 1'b1;
              state <= HI;
            end else begin
              phase <= phase + 1'b1;
            end
          end
          TAIL: begin
            if (last_phase) begin
              phase <= '0;
              done  <= 1'b1;
              if (accept) begin
                shreg   <= in_data;
                bit_idx <= 3'd7;
                mosi    <= in_data[7];
                state   <= SETUP;
              end else begin
                cs_n  <= 1'b1;
                mosi  <= 1'b0;
                state <= IDLE;
              end
            end else begin
              phase <= phase + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            phase <= '0;
            sck   <= 1'b0;
            mosi  <= 1'b0;
            cs_n  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_encoder.sv
// Directed bench for spi_encoder: dut0 runs with CLK_DIV=2, dut1 with CLK_DIV=1.
// A negedge monitor reassembles bytes from mosi at sck rises and checks them against a queue.
module tb_spi_encoder;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n    [2];
  logic [7:0] in_data  [2];
  logic       in_valid [2];
  logic       abort    [2];
  logic       in_ready [2];
  logic       sck      [2];
  logic       mosi     [2];
  logic       cs_n     [2];
  logic       busy     [2];
  logic       done     [2];

  spi_encoder #(.CLK_DIV(2)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .abort(abort[0]), .sck(sck[0]), .mosi(mosi[0]),
    .cs_n(cs_n[0]), .busy(busy[0]), .done(done[0])
  );

  spi_encoder #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .abort(abort[1]), .sck(sck[1]), .mosi(mosi[1]),
    .cs_n(cs_n[1]), .busy(busy[1]), .done(done[1])
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0] exp_q[$];
  int         done_cnt [2];
  int         bits     [2];
  logic [7:0] rx       [2];
  logic       prev_sck [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard side: bytes are rebuilt independently of the design and popped on done.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n[d]) begin
        bits[d]     = 0;
        prev_sck[d] = 1'b0;
      end else begin
        if (sck[d] && !prev_sck[d]) begin
          rx[d]   = {rx[d][6:0], mosi[d]};
          bits[d] = bits[d] + 1;
        end
        prev_sck[d] = sck[d];
        if (done[d]) begin
          done_cnt[d] = done_cnt[d] + 1;
          chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            logic [8:0] e;
            e = exp_q.pop_front();
            chk("sb_byte", {23'd0, d[0], rx[d]}, {23'd0, e});
            chk("sb_bits", bits[d], 32'd8);
          end
          bits[d] = 0;
        end else if (cs_n[d]) begin
          bits[d] = 0;
        end
      end
    end
  end

  task automatic send(input int d, input logic [7:0] b, input bit push);
    int n;
    @(negedge clk);
    in_data[d]  = b;
    in_valid[d] = 1'b1;
    n = 0;
    while (!in_ready[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(n < 200), 32'd1);
    if (push) exp_q.push_back({d[0], b});
    @(posedge clk);
    #1 in_valid[d] = 1'b0;
  endtask

  // Called right after an accept edge: first negedge seen is cycle 1.
  task automatic watch(input int d, output int low, output int rises, output int first_r,
                       output int last_r, output int done_at, output logic cs_at_done);
    logic p;
    p = 1'b0; low = 0; rises = 0; first_r = 0; last_r = 0; done_at = 0; cs_at_done = 1'bx;
    for (int k = 1; k <= 200 && done_at == 0; k++) begin
      @(negedge clk);
      if (!cs_n[d]) low++;
      if (sck[d] && !p) begin
        rises++;
        if (first_r == 0) first_r = k;
        last_r = k;
      end
      p = sck[d];
      if (done[d]) begin
        done_at    = k;
        cs_at_done = cs_n[d];
      end
    end
  endtask

  initial begin
    int low, rises, fr, lr, dat, acc_k, t1, t2, hi_cnt, dn, r, n, dc, nr_seen;
    logic csd, p;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; in_data[d] = 8'h00; in_valid[d] = 1'b0; abort[d] = 1'b0;
      done_cnt[d] = 0; bits[d] = 0; rx[d] = 8'h00; prev_sck[d] = 1'b0;
    end
    #22;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_sck", sck[d], 0);
      chk("rst_mosi", mosi[d], 0);
      chk("rst_cs_n", cs_n[d], 1);
      chk("rst_done", done[d], 0);
      chk("rst_busy", busy[d], 0);
      chk("rst_in_ready", in_ready[d], 1);
    end

    // single byte A5, CLK_DIV=2
    send(0, 8'hA5, 1);
    watch(0, low, rises, fr, lr, dat, csd);
    chk("a5_cs_low", low, 34);
    chk("a5_rises", rises, 8);
    chk("a5_first_rise", fr, 3);
    chk("a5_last_rise", lr, 31);
    chk("a5_done_cycle", dat, 35);
    chk("a5_cs_at_done", csd, 1);

    // back-to-back 3C, C3 with in_valid held
    @(negedge clk);
    in_data[0] = 8'h3C; in_valid[0] = 1'b1;
    n = 0;
    while (!in_ready[0] && n < 50) begin @(negedge clk); n++; end
    exp_q.push_back({1'b0, 8'h3C});
    @(posedge clk);
    #1 in_data[0] = 8'hC3;
    acc_k = 0; t1 = 0; t2 = 0; hi_cnt = 0; dn = 0;
    for (int k = 1; k <= 150 && dn < 2; k++) begin
      @(negedge clk);
      if (done[0]) begin
        dn++;
        if (dn == 1) t1 = k; else t2 = k;
      end
      if (cs_n[0] && dn < 2) hi_cnt++;
      if (in_ready[0] && in_valid[0]) begin
        acc_k = k;
        exp_q.push_back({1'b0, 8'hC3});
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
      end
    end
    chk("b2b_accept_cycle", acc_k, 34);
    chk("b2b_done1", t1, 35);
    chk("b2b_done2", t2, 69);
    chk("b2b_done_gap", t2 - t1, 34);
    chk("b2b_cs_high", hi_cnt, 0);

    // abort after third rising sck of FF
    send(0, 8'hFF, 0);
    r = 0; p = 1'b0; n = 0;
    while (r < 3 && n < 100) begin
      @(negedge clk);
      if (sck[0] && !p) r++;
      p = sck[0];
      n++;
    end
    chk("abort_reach_rise3", r, 3);
    dc = done_cnt[0];
    abort[0] = 1'b1;
    @(posedge clk);
    #1 abort[0] = 1'b0;
    @(negedge clk);
    chk("abort_cs_n", cs_n[0], 1);
    chk("abort_sck", sck[0], 0);
    chk("abort_mosi", mosi[0], 0);
    chk("abort_busy", busy[0], 0);
    chk("abort_in_ready", in_ready[0], 1);
    repeat (40) @(negedge clk);
    chk("abort_no_done", done_cnt[0], dc);

    // async reset during HI, then 81
    send(0, 8'h5A, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!sck[0] && n < 50);
    chk("rst_reach_hi", sck[0], 1);
    dc = done_cnt[0];
    #1 rst_n[0] = 1'b0;
    #1;
    chk("midrst_sck", sck[0], 0);
    chk("midrst_cs_n", cs_n[0], 1);
    chk("midrst_mosi", mosi[0], 0);
    chk("midrst_busy", busy[0], 0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_idle_ready", in_ready[0], 1);
    chk("midrst_no_done", done_cnt[0], dc);
    send(0, 8'h81, 1);
    watch(0, low, rises, fr, lr, dat, csd);
    chk("x81_cs_low", low, 34);
    chk("x81_done_cycle", dat, 35);

    // CLK_DIV=1: 00 then FF with a gap
    send(1, 8'h00, 1);
    watch(1, low, rises, fr, lr, dat, csd);
    chk("d1_00_cs_low", low, 17);
    chk("d1_00_rises", rises, 8);
    chk("d1_00_first_rise", fr, 2);
    chk("d1_00_last_rise", lr, 16);
    chk("d1_00_done", dat, 18);
    chk("d1_00_cs_high_after", csd, 1);
    repeat (2) @(negedge clk);
    chk("d1_gap_cs_high", cs_n[1], 1);
    send(1, 8'hFF, 1);
    watch(1, low, rises, fr, lr, dat, csd);
    chk("d1_ff_cs_low", low, 17);
    chk("d1_ff_done", dat, 18);

    // in_valid while busy is held off; in-flight byte is unaffected
    dc = done_cnt[0];
    send(0, 8'h96, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!sck[0] && n < 50);
    in_data[0] = 8'h4B; in_valid[0] = 1'b1;
    chk("busy_not_ready", in_ready[0], 0);
    nr_seen = 0; acc_k = 0;
    for (int k = 1; k <= 100 && acc_k == 0; k++) begin
      @(negedge clk);
      if (in_ready[0]) begin
        acc_k = k;
        chk("late_accept_cs_low", cs_n[0], 0);
        exp_q.push_back({1'b0, 8'h4B});
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
      end else begin
        nr_seen++;
      end
    end
    chk("late_accepted", 32'(acc_k != 0), 32'd1);
    chk("late_held_cycles", 32'(nr_seen > 20), 32'd1);
    n = 0;
    while (done_cnt[0] < dc + 2 && n < 200) begin @(negedge clk); n++; end
    chk("late_two_dones", done_cnt[0], dc + 2);

    repeat (5) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
